// File: rtl/instr_issuer_if.sv
// Instruction-memory read port and controller issue port of instr_issuer.
// master = issuer side, slave = memory/controller side.
interface instr_issuer_if;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        start;

    modport master (
        output imem_en,
        output imem_addr,
        output instruction,
        output start,
        input  imem_rdata
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        input  instruction,
        input  start,
        output imem_rdata
    );
endinterface

// File: rtl/instr_issuer.sv
// Fetches instructions from a 1-cycle-latency memory and issues them to a bit-serial
// controller with a per-opcode cycle budget. Optional macro ISSUER_TRACE_EN adds a retirement counter.
module instr_issuer #(
    parameter int LENGTH     = 32,
    parameter int MUL_CYCLES = 2400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    instr_issuer_if.master bus,
    output logic        busy,
    output logic        halted,
    output logic        err_illegal,
    output logic [9:0]  pc
`ifdef ISSUER_TRACE_EN
    ,
    output logic [15:0] retired
`endif
);

    localparam int LONG_BUDGET = 2 * LENGTH + 2;
    localparam int MAX_BUDGET  = (MUL_CYCLES > LONG_BUDGET) ? MUL_CYCLES : LONG_BUDGET;
    localparam int CNT_W       = ($clog2(MAX_BUDGET + 1) > 16) ? $clog2(MAX_BUDGET + 1) : 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        ISSUE,
        EXEC,
        HALT
    } state_t;

    state_t            state, state_n;
    logic [9:0]        pc_q, pc_n;
    logic [31:0]       instr_q, instr_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              err_q, err_n;
    logic              retire;
    logic [5:0]        rd_op;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'd0, 6'd1, 6'd2, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11};
    endfunction

    function automatic logic [CNT_W-1:0] budget_of(input logic [5:0] op);
        logic [CNT_W-1:0] b;
        unique case (op)
            6'd0, 6'd1, 6'd9, 6'd10: b = CNT_W'(2 * LENGTH + 2);
            6'd5, 6'd6, 6'd7, 6'd11: b = CNT_W'(LENGTH + 2);
            6'd8:                    b = CNT_W'(LENGTH + 3);
            6'd2:                    b = CNT_W'(MUL_CYCLES);
            default:                 b = CNT_W'(1);
        endcase
        return b;
    endfunction

    assign rd_op = bus.imem_rdata[31:26];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        instr_n = instr_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        retire  = 1'b0;
        unique case (state)
            IDLE, HALT: begin
                if (run) begin
                    pc_n    = '0;
                    err_n   = 1'b0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = WAIT_MEM;
            WAIT_MEM: begin
                if (rd_op == 6'd63) begin
                    state_n = HALT;
                end else if (is_legal(rd_op)) begin
                    instr_n = bus.imem_rdata;
                    state_n = ISSUE;
                end else begin
                    // Illegal words are skipped: instruction keeps the last issued word.
                    err_n   = 1'b1;
                    pc_n    = pc_q + 10'd1;
                    state_n = FETCH;
                end
            end
            ISSUE: begin
                cnt_n   = budget_of(instr_q[31:26]);
                state_n = EXEC;
            end
            EXEC: begin
                cnt_n = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                // A zero budget retires like a budget of one so the FSM cannot stall.
                if (cnt_q <= CNT_W'(1)) begin
                    pc_n    = pc_q + 10'd1;
                    retire  = 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.imem_en     = (state == FETCH);
    assign bus.imem_addr   = (state == FETCH) ? pc_q : '0;
    assign bus.start       = (state == ISSUE);
    assign bus.instruction = instr_q;
    assign busy            = (state == FETCH) || (state == WAIT_MEM) ||
                             (state == ISSUE) || (state == EXEC);
    assign halted          = (state == HALT);
    assign err_illegal     = err_q;
    assign pc              = pc_q;

`ifdef ISSUER_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (retire && (retired != 16'hFFFF)) begin
            retired <= retired + 16'd1;
        end
    end
`endif

    a_start_single: assert property (@(posedge clk) disable iff (reset) bus.start |=> !bus.start);
    a_start_exec:   assert property (@(posedge clk) disable iff (reset) bus.start |=> (state == EXEC));

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed programs plus random programs
// compared against an event-timing model derived from the fetch/issue/budget rules.
module tb_instr_issuer;
    localparam int LEN  = 32;
    localparam int MULC = 120;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       busy, halted, err_illegal;
    logic [9:0] pc;
`ifdef ISSUER_TRACE_EN
    logic [15:0] retired;
`endif

    instr_issuer_if bus();

    instr_issuer #(.LENGTH(LEN), .MUL_CYCLES(MULC)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .err_illegal (err_illegal),
        .pc          (pc)
`ifdef ISSUER_TRACE_EN
        ,
        .retired     (retired)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

    int errors = 0;
    int checks = 0;
    int ncyc = 0;

    int          act_fetch_cyc[$];
    int          act_fetch_addr[$];
    int          act_start_cyc[$];
    logic [31:0] act_start_instr[$];
    int          act_halt_cyc = -1;
    int          stab_viol = 0;
    int          consec_viol = 0;
    logic        prev_start = 1'b0;
    logic        prev_halted = 1'b0;
    logic [31:0] prev_instr = '0;

    int          exp_fetch_cyc[$];
    int          exp_fetch_addr[$];
    int          exp_start_cyc[$];
    logic [31:0] exp_start_instr[$];
    int          exp_halt_cyc;
    logic        exp_err;
    logic [9:0]  exp_pc;

    // Monitor: cycle n is the clock period whose falling edge is the n-th.
    always @(negedge clk) begin
        ncyc++;
        if (bus.imem_en) begin
            act_fetch_cyc.push_back(ncyc);
            act_fetch_addr.push_back(int'(bus.imem_addr));
        end
        if (bus.start) begin
            act_start_cyc.push_back(ncyc);
            act_start_instr.push_back(bus.instruction);
            if (prev_start) consec_viol++;
        end else if (bus.instruction !== prev_instr) begin
            stab_viol++;
        end
        if (halted && !prev_halted) act_halt_cyc = ncyc;
        prev_start  = bus.start;
        prev_halted = halted;
        prev_instr  = bus.instruction;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        act_fetch_cyc.delete();
        act_fetch_addr.delete();
        act_start_cyc.delete();
        act_start_instr.delete();
        act_halt_cyc = -1;
        stab_viol = 0;
        consec_viol = 0;
    endtask

    task automatic pulse_run(output int rc);
        tick();
        run = 1'b1;
        rc = ncyc + 1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int bound);
        int n = 0;
        while (!halted && n < bound) begin
            tick();
            n++;
        end
        if (!halted) check({tag, "_halt_timeout"}, 64'(halted), 64'd1);
        tick();
        tick();
    endtask

    task automatic wait_start(input string tag, input int bound);
        int n = 0;
        while (!bus.start && n < bound) begin
            tick();
            n++;
        end
        if (!bus.start) check({tag, "_start_timeout"}, 64'(bus.start), 64'd1);
    endtask

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {6'd0, 6'd1, 6'd2, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11};
    endfunction

    function automatic int op_budget(input logic [5:0] op);
        if (op inside {6'd0, 6'd1, 6'd9, 6'd10}) return 2 * LEN + 2;
        if (op inside {6'd5, 6'd6, 6'd7, 6'd11}) return LEN + 2;
        if (op == 6'd8) return LEN + 3;
        return MULC;
    endfunction

    // Reference: fetch at t, decode at t+1; a legal word starts at t+2 and the
    // next fetch follows its budget; an illegal word refetches at t+2.
    task automatic model_run(input int rc);
        int          t;
        logic [9:0]  p;
        logic [31:0] w;
        exp_fetch_cyc.delete();
        exp_fetch_addr.delete();
        exp_start_cyc.delete();
        exp_start_instr.delete();
        exp_halt_cyc = -1;
        exp_err = 1'b0;
        t = rc + 1;
        p = '0;
        for (int n = 0; n < 1100; n++) begin
            exp_fetch_cyc.push_back(t);
            exp_fetch_addr.push_back(int'(p));
            w = mem[p];
            if (w[31:26] == 6'd63) begin
                exp_halt_cyc = t + 2;
                break;
            end
            if (op_legal(w[31:26])) begin
                exp_start_cyc.push_back(t + 2);
                exp_start_instr.push_back(w);
                t = t + 3 + op_budget(w[31:26]);
            end else begin
                exp_err = 1'b1;
                t = t + 2;
            end
            p = p + 10'd1;
        end
        exp_pc = p;
    endtask

    task automatic compare_run(input string tag);
        check({tag, "_n_fetch"}, 64'(act_fetch_cyc.size()), 64'(exp_fetch_cyc.size()));
        check({tag, "_n_start"}, 64'(act_start_cyc.size()), 64'(exp_start_cyc.size()));
        for (int i = 0; i < exp_fetch_cyc.size() && i < act_fetch_cyc.size(); i++) begin
            check($sformatf("%s_fetch%0d_cyc", tag, i), 64'(act_fetch_cyc[i]), 64'(exp_fetch_cyc[i]));
            check($sformatf("%s_fetch%0d_addr", tag, i), 64'(act_fetch_addr[i]), 64'(exp_fetch_addr[i]));
        end
        for (int i = 0; i < exp_start_cyc.size() && i < act_start_cyc.size(); i++) begin
            check($sformatf("%s_start%0d_cyc", tag, i), 64'(act_start_cyc[i]), 64'(exp_start_cyc[i]));
            check($sformatf("%s_start%0d_instr", tag, i), 64'(act_start_instr[i]), 64'(exp_start_instr[i]));
        end
        check({tag, "_halt_cyc"}, 64'(act_halt_cyc), 64'(exp_halt_cyc));
        check({tag, "_err"}, 64'(err_illegal), 64'(exp_err));
        check({tag, "_pc"}, 64'(pc), 64'(exp_pc));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd1);
        check({tag, "_instr_stable"}, 64'(stab_viol), 64'd0);
        check({tag, "_start_spacing"}, 64'(consec_viol), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_start"}, 64'(bus.start), 64'd0);
        check({tag, "_imem_en"}, 64'(bus.imem_en), 64'd0);
        check({tag, "_imem_addr"}, 64'(bus.imem_addr), 64'd0);
        check({tag, "_instruction"}, 64'(bus.instruction), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_err"}, 64'(err_illegal), 64'd0);
        check({tag, "_pc"}, 64'(pc), 64'd0);
    endtask

    initial begin
        int          rc;
        int          dummy;
        logic [9:0]  pc_before;
        logic [5:0]  op;
        logic [5:0]  legal_ops [10];

        legal_ops = '{6'd0, 6'd1, 6'd2, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11};
        for (int i = 0; i < 1024; i++) mem[i] = HALT_W;

        reset = 1'b1;
        repeat (3) tick();
        check_reset_state("por");
        reset = 1'b0;
        tick();

        // Program A: one opcode-1 instruction, then HALT.
        mem[0] = 32'h0400_0000;
        mem[1] = HALT_W;
        clear_mon();
        pulse_run(rc);
        model_run(rc);
        wait_halt("A", 400);
        compare_run("A");
        check("A_start_latency", 64'(act_start_cyc[0] - rc), 64'd3);
        check("A_next_fetch", 64'(act_fetch_cyc[1] - act_start_cyc[0]), 64'd67);

        // Program B: opcode 5 then opcode 8; restarted out of HALT.
        mem[0] = {6'd5, 26'h12_3456};
        mem[1] = {6'd8, 26'h0AB_CDEF};
        mem[2] = HALT_W;
        clear_mon();
        pulse_run(rc);
        model_run(rc);
        wait_halt("B", 400);
        compare_run("B");
        check("B_spacing_5", 64'(act_start_cyc[1] - act_start_cyc[0]), 64'd37);
        check("B_spacing_8", 64'(act_halt_cyc - act_start_cyc[1]), 64'd38);

        // Program C: illegal opcode skipped, flag set.
        mem[0] = {6'd3, 26'h3FF_FFFF};
        mem[1] = {6'd0, 26'h000_0042};
        mem[2] = HALT_W;
        clear_mon();
        pulse_run(rc);
        model_run(rc);
        tick();
        tick();
        check("C_err_after_decode", 64'(err_illegal), 64'd1);
        wait_halt("C", 400);
        compare_run("C");
        check("C_one_start", 64'(act_start_cyc.size()), 64'd1);
        check("C_start_op", 64'(act_start_instr[0][31:26]), 64'd0);
        check("C_pc", 64'(pc), 64'd2);

        // Reset in the middle of an opcode-2 execution.
        mem[0] = {6'd2, 26'h155_5555};
        mem[1] = HALT_W;
        clear_mon();
        pulse_run(rc);
        wait_start("D", 20);
        repeat (20) tick();
        check("D_busy_in_exec", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        check_reset_state("D_rst");
        reset = 1'b0;
        clear_mon();
        repeat (200) tick();
        check("D_no_start", 64'(act_start_cyc.size()), 64'd0);
        check("D_idle", 64'(busy), 64'd0);

        // run pulsed during EXEC must be ignored.
        mem[0] = {6'd0, 26'h0F0_F0F0};
        mem[1] = {6'd1, 26'h30F_0F0F};
        mem[2] = HALT_W;
        clear_mon();
        pulse_run(rc);
        model_run(rc);
        repeat (30) tick();
        pc_before = pc;
        pulse_run(dummy);
        check("E_pc_unchanged", 64'(pc), 64'(pc_before));
        check("E_busy", 64'(busy), 64'd1);
        wait_halt("E", 400);
        compare_run("E");
`ifdef ISSUER_TRACE_EN
        check("E_retired", 64'(retired), 64'd2);
`endif

        // Random programs, each restarted from HALT.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 9)];
                else if ($urandom_range(0, 1) == 0) op = 6'($urandom_range(3, 4));
                else op = 6'($urandom_range(12, 62));
                mem[i] = {op, 26'($urandom)};
            end
            mem[8] = HALT_W;
            clear_mon();
            pulse_run(rc);
            model_run(rc);
            wait_halt($sformatf("R%0d", k), 3000);
            compare_run($sformatf("R%0d", k));
        end

        // pc wrap: walk illegal words through 1023 back to 0, where HALT now sits.
        mem[0] = {6'd5, 26'h0};
        for (int i = 1; i < 1024; i++) mem[i] = {6'd3, 26'(i)};
        clear_mon();
        pulse_run(rc);
        wait_start("W", 20);
        mem[0] = HALT_W;
        wait_halt("W", 3000);
        check("W_pc", 64'(pc), 64'd0);
        check("W_err", 64'(err_illegal), 64'd1);
        check("W_n_start", 64'(act_start_cyc.size()), 64'd1);
        check("W_n_fetch", 64'(act_fetch_cyc.size()), 64'd1025);
        check("W_last_addr", 64'(act_fetch_addr[act_fetch_addr.size() - 1]), 64'd0);
        check("W_wrap_addr", 64'(act_fetch_addr[1023]), 64'd1023);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 SHALL have parameter LENGTH, default 32, meaning the bit-serial word length the downstream controller uses.
REQ-002 SHALL have parameter MUL_CYCLES, default 2400, meaning the cycle budget for opcode 2 (multiply).
REQ-003 SHALL have ports clk (input, 1, clock) and reset (input, 1, synchronous active-high reset); one clock, all logic on rising clk.
REQ-004 SHALL have port run (input, 1): a one-cycle pulse that starts program execution from address 0.
REQ-005 SHALL have ports imem_en (output, 1, read strobe) and imem_addr (output, 10, word address).
REQ-006 SHALL have port imem_rdata (input, 32): instruction word, valid exactly 1 cycle after imem_en.
REQ-007 SHALL have ports instruction (output, 32, word to the controller) and start (output, 1, one-cycle issue pulse).
REQ-008 SHALL have ports busy (output, 1), halted (output, 1), err_illegal (output, 1, sticky) and pc (output, 10, address of the current instruction).

Function
REQ-009 SHALL implement states IDLE, FETCH, WAIT_MEM, ISSUE, EXEC and HALT.
REQ-010 IDLE: on run=1, set pc=0 and busy=1, then go to FETCH; otherwise stay in IDLE.
REQ-011 FETCH: assert imem_en=1 with imem_addr=pc for one cycle, then go to WAIT_MEM.
REQ-012 WAIT_MEM: capture imem_rdata and decode opcode=[31:26].
- Opcode 63: go to HALT.
- Legal opcode (0,1,2,5,6,7,8,9,10,11): load instruction, go to ISSUE.
- Any other opcode: set err_illegal=1, increment pc, go to FETCH; instruction is not updated and start is not pulsed.
REQ-013 ISSUE: assert start=1 for exactly one cycle, load the exec counter with the budget, go to EXEC.
REQ-014 Budgets: opcodes 0,1,9,10 -> 2*LENGTH+2; 5,6,7,11 -> LENGTH+2; 8 -> LENGTH+3; 2 -> MUL_CYCLES.
REQ-015 EXEC: decrement the counter each cycle; on the cycle it reads 1, increment pc and go to FETCH.
REQ-016 instruction SHALL be held constant from ISSUE until the next ISSUE, because the controller decodes it combinationally throughout execution.
REQ-017 pc SHALL wrap from 1023 to 0 with no error flag; the exec counter SHALL be at least 16 bits wide.
REQ-018 HALT: busy=0 and halted=1; stay in HALT until run=1, which restarts from FETCH at pc=0 and clears halted.
REQ-019 run SHALL be ignored in every state except IDLE and HALT; no re-issue while busy.
REQ-020 start SHALL never be asserted in two consecutive cycles; the minimum spacing between start pulses is budget+3 cycles.
REQ-021 err_illegal SHALL clear only on reset, or on run accepted in IDLE or HALT.

Reset
REQ-022 On reset=1 at a rising clk edge, regardless of state:
- state=IDLE, pc=0, instruction=0, start=0, imem_en=0, imem_addr=0;
- busy=0, halted=0, err_illegal=0, exec counter=0.
REQ-023 Reset asserted during EXEC SHALL abort the current instruction with no further start; the controller is reset separately by its own active-low reset.
REQ-024 Reset has priority over run when both are asserted in the same cycle.

Configuration
REQ-025 Macro ISSUER_TRACE_EN SHALL gate a retirement counter.
- Defined: add output retired (16 bits, reset 0), incremented on each EXEC->FETCH transition, saturating at 65535.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-026 Program {0x04000000 (opcode 1), 0xFC000000} with run pulse at cycle 10 -> start at cycle 13; next imem_en at cycle 13+66+1; halted=1 after the HALT fetch; busy=0.
REQ-027 Program {opcode 5, opcode 8, HALT} -> start pulses 37 cycles apart and then 38 cycles apart (LENGTH=32); instruction stable between pulses.
REQ-028 Program {opcode 3, opcode 0, HALT} -> err_illegal=1 after the first decode; exactly one start pulse, carrying opcode 0; pc reaches 2.
REQ-029 Reset asserted 20 cycles into an opcode-2 EXEC -> next cycle state=IDLE, all outputs 0; no start until the next run.
REQ-030 run pulsed during EXEC -> ignored, pc is unchanged; with ISSUER_TRACE_EN defined, retired counts 2 after two instructions complete.
